// File: rtl/pp_pipeline_accel_start_fifo_srl.sv
// Shift-register FIFO for start tokens and small scalars between dataflow processes.
// FWFT read side, registered occupancy/status flags, synchronous flush and sticky error flags.
module pp_pipeline_accel_start_fifo_srl #(
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 3,
   parameter int ADDR_WIDTH = 2,
   parameter int AF_LEVEL   = DEPTH - 1,
   parameter int AE_LEVEL   = 1,
   localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] if_din,
   input  logic                  if_write,
   input  logic                  if_write_ce,
   output logic                  if_full_n,
   output logic [DATA_WIDTH-1:0] if_dout,
   input  logic                  if_read,
   input  logic                  if_read_ce,
   output logic                  if_empty_n,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  err_overflow,
   output logic                  err_underflow
);

   localparam logic [CNT_WIDTH-1:0] CNT_DEPTH = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_AF    = CNT_WIDTH'(AF_LEVEL);
   localparam logic [CNT_WIDTH-1:0] CNT_AE    = CNT_WIDTH'(AE_LEVEL);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  empty_n_q, full_n_q, af_q, ae_q, ovf_q, unf_q;
   logic                  wr_req, rd_req, wr_acc, rd_acc, shift_en;
   logic [ADDR_WIDTH-1:0] rd_addr;

   // Acceptance uses only the registered flags, so a full FIFO never passes a write through
   // on a concurrent read and an empty FIFO never passes a read through on a concurrent write.
   assign wr_req   = if_write & if_write_ce;
   assign rd_req   = if_read & if_read_ce;
   assign wr_acc   = wr_req & full_n_q;
   assign rd_acc   = rd_req & empty_n_q;
   assign shift_en = wr_acc & ~flush & ~reset;

   always_comb begin
      rd_addr = '0;
      if (count_q != '0) begin
         rd_addr = ADDR_WIDTH'(count_q - CNT_ONE);
      end
   end

   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (wr_acc && !rd_acc) begin
         count_d = count_q + CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - CNT_ONE;
      end
   end

   // Storage is deliberately not reset; the count decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (shift_en) begin
         mem_q[0] <= if_din;
         for (int i = 1; i < DEPTH; i++) begin
            mem_q[i] <= mem_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         empty_n_q <= 1'b0;
         full_n_q  <= 1'b1;
         af_q      <= 1'b0;
         ae_q      <= 1'b1;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         empty_n_q <= (count_d != '0);
         full_n_q  <= (count_d != CNT_DEPTH);
         af_q      <= (count_d >= CNT_AF);
         ae_q      <= (count_d <= CNT_AE);
         ovf_q     <= ovf_q | (wr_req & ~full_n_q);
         unf_q     <= unf_q | (rd_req & ~empty_n_q);
      end
   end

   assign if_dout       = mem_q[rd_addr];
   assign if_full_n     = full_n_q;
   assign if_empty_n    = empty_n_q;
   assign count         = count_q;
   assign almost_full   = af_q;
   assign almost_empty  = ae_q;
   assign err_overflow  = ovf_q;
   assign err_underflow = unf_q;

endmodule

// File: tb/tb_pp_pipeline_accel_start_fifo_srl.sv
// Bench for the start FIFO: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model.
module tb_pp_pipeline_accel_start_fifo_srl;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int AF    = 3;
   localparam int AE    = 1;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          reset, flush, if_write, if_write_ce, if_read, if_read_ce;
   logic [DW-1:0] if_din;
   logic          if_full_n, if_empty_n, almost_full, almost_empty, err_overflow, err_underflow;
   logic [DW-1:0] if_dout;
   logic [CW-1:0] count;

   pp_pipeline_accel_start_fifo_srl #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .if_din(if_din), .if_write(if_write), .if_write_ce(if_write_ce), .if_full_n(if_full_n),
      .if_dout(if_dout), .if_read(if_read), .if_read_ce(if_read_ce), .if_empty_n(if_empty_n),
      .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
      .err_overflow(err_overflow), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mq[$];
   bit            m_ovf, m_unf;
   bit            chk_en = 1'b0;
   int            n_vec = 0;
   int            n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue, oldest at the front.
   always @(posedge clk) begin : model
      bit wreq, rreq, full, empty;
      if (reset) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         wreq  = if_write && if_write_ce;
         rreq  = if_read && if_read_ce;
         full  = (mq.size() == DEPTH);
         empty = (mq.size() == 0);
         if (wreq && full)  m_ovf = 1'b1;
         if (rreq && empty) m_unf = 1'b1;
         if (flush) begin
            mq.delete();
         end else begin
            if (rreq && !empty) void'(mq.pop_front());
            if (wreq && !full)  mq.push_back(if_din);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("count",         32'(count),         32'(mq.size()));
         chk("if_empty_n",    32'(if_empty_n),    32'(mq.size() != 0));
         chk("if_full_n",     32'(if_full_n),     32'(mq.size() != DEPTH));
         chk("almost_full",   32'(almost_full),   32'(mq.size() >= AF));
         chk("almost_empty",  32'(almost_empty),  32'(mq.size() <= AE));
         chk("err_overflow",  32'(err_overflow),  32'(m_ovf));
         chk("err_underflow", 32'(err_underflow), 32'(m_unf));
         if (mq.size() > 0) chk("if_dout", 32'(if_dout), 32'(mq[0]));
      end
   end

   task automatic cyc(input bit w, input bit wce, input logic [DW-1:0] d,
                      input bit r, input bit rce, input bit fl, input bit rst);
      if_write    = w;
      if_write_ce = wce;
      if_din      = d;
      if_read     = r;
      if_read_ce  = rce;
      flush       = fl;
      reset       = rst;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [DW-1:0] d);
      cyc(1'b1, 1'b1, d, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic rd();
      cyc(1'b0, 1'b1, '0, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      cyc(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   logic [DW-1:0] exp_fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [DW-1:0] exp_rw   [3] = '{8'hA0, 8'hA1, 8'hA2};

   initial begin
      bit w, r, fl, rst, bias;
      reset = 1'b1; flush = 1'b0; if_write = 1'b0; if_write_ce = 1'b1;
      if_read = 1'b0; if_read_ce = 1'b1; if_din = '0;
      do_reset();
      chk_en = 1'b1;
      do_reset();

      chk("rst_empty_n", 32'(if_empty_n), 0);
      chk("rst_full_n",  32'(if_full_n), 1);
      chk("rst_count",   32'(count), 0);
      chk("rst_ae",      32'(almost_empty), 1);
      chk("rst_af",      32'(almost_full), 0);
      chk("rst_ovf",     32'(err_overflow), 0);
      chk("rst_unf",     32'(err_underflow), 0);

      // Fill to full.
      wr(8'h11); wr(8'h22);
      chk("af_after2", 32'(almost_full), 0);
      wr(8'h33);
      chk("af_after3", 32'(almost_full), 1);
      wr(8'h44);
      chk("count_full", 32'(count), 4);
      chk("full_n_full", 32'(if_full_n), 0);
      chk("model_full", 32'(mq.size()), 4);

      // Write without clock-enable at full: nothing happens.
      cyc(1'b1, 1'b0, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("ce_count", 32'(count), 4);
      chk("ce_ovf", 32'(err_overflow), 0);

      wr(8'h55);
      chk("ovf_set", 32'(err_overflow), 1);
      chk("ovf_count", 32'(count), 4);

      for (int i = 0; i < 4; i++) begin
         chk("drain_dout", 32'(if_dout), 32'(exp_fill[i]));
         rd();
      end
      chk("drain_count", 32'(count), 0);
      chk("drain_empty_n", 32'(if_empty_n), 0);

      // Simultaneous read+write at count 2.
      do_reset();
      wr(8'hA0); wr(8'hA1);
      for (int i = 0; i < 3; i++) begin
         chk("rw_dout", 32'(if_dout), 32'(exp_rw[i]));
         cyc(1'b1, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b0, 1'b0);
         chk("rw_count", 32'(count), 2);
      end
      rd(); rd();
      chk("rw_drained", 32'(count), 0);

      // Read+write from empty: read refused.
      cyc(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("unf_set", 32'(err_underflow), 1);
      chk("unf_count", 32'(count), 1);
      chk("unf_dout", 32'(if_dout), 32'h5A);

      // Flush with a concurrent write at count 3.
      wr(8'h01); wr(8'h02);
      chk("pre_flush_count", 32'(count), 3);
      cyc(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("fl_count", 32'(count), 0);
      chk("fl_empty_n", 32'(if_empty_n), 0);
      chk("fl_full_n", 32'(if_full_n), 1);
      chk("fl_ae", 32'(almost_empty), 1);
      chk("fl_af", 32'(almost_full), 0);
      chk("fl_ovf", 32'(err_overflow), 0);
      chk("fl_unf_sticky", 32'(err_underflow), 1);
      wr(8'h3C);
      chk("post_fl_count", 32'(count), 1);
      chk("post_fl_dout", 32'(if_dout), 32'h3C);

      // Random traffic with alternating fill/drain bias.
      bias = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 150 == 0) bias = ~bias;
         w   = ($urandom_range(0, 99) < (bias ? 70 : 30));
         r   = ($urandom_range(0, 99) < (bias ? 30 : 70));
         fl  = ($urandom_range(0, 39) == 0);
         rst = ($urandom_range(0, 299) == 0);
         cyc(w, ($urandom_range(0, 9) != 0), DW'($urandom), r, ($urandom_range(0, 9) != 0), fl, rst);
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pp_pipeline_accel_start_fifo_srl.md
# pp_pipeline_accel_start_fifo_srl

Parametrised shift-register FIFO for start-token and small scalar channels between dataflow processes in the pp_pipeline_accel core. Generalises the fixed-depth start FIFO to any DEPTH ≥ 2 and adds a visible occupancy count, almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. The read side is first-word-fall-through, and the handshake stays compatible with the existing empty_n/full_n process interface.

## Interface
- DATA_WIDTH, 1, token/data width in bits
- DEPTH, 3, number of entries; legal range ≥ 2
- ADDR_WIDTH, 2, storage address width; must equal clog2(DEPTH)
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1
- CNT_WIDTH (derived localparam), clog2(DEPTH+1)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous discard of all contents
- if_din  in  DATA_WIDTH  write data
- if_write  in  1  write request
- if_write_ce  in  1  write clock-enable; a write counts only when if_write & if_write_ce
- if_full_n  out  1  1 = space available
- if_dout  out  DATA_WIDTH  head-of-queue data, FWFT
- if_read  in  1  read request
- if_read_ce  in  1  read clock-enable; a read counts only when if_read & if_read_ce
- if_empty_n  out  1  1 = data available
- count  out  CNT_WIDTH  current occupancy, 0..DEPTH
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- err_overflow  out  1  sticky: a write was attempted while full
- err_underflow  out  1  sticky: a read was attempted while empty

## Operation
- Definitions:
  - wr_req = if_write & if_write_ce; rd_req = if_read & if_read_ce.
  - wr_acc = wr_req & if_full_n; rd_acc = rd_req & if_empty_n.
- Storage: DEPTH × DATA_WIDTH shift register, not reset.
  - On wr_acc, all entries shift up one position and if_din enters entry 0.
  - Storage contents are unaffected by flush.
- Read address:
  - count-1 when count > 0, else 0.
  - if_dout is combinational from the addressed entry; its value while if_empty_n=0 is don't-care.
- Occupancy update, in priority order:
  - reset: count=0.
  - flush: count=0; any wr_acc/rd_acc in the same cycle is discarded and the storage does not shift.
  - wr_acc & !rd_acc: count+1.
  - rd_acc & !wr_acc: count-1.
  - both accepted: count unchanged; storage shifts, so the next-oldest entry appears at the same address.
- No pass-through:
  - A write to a full FIFO is refused even if a read is accepted in the same cycle.
  - A read from an empty FIFO is refused even if a write is accepted in the same cycle.
- All status outputs are registers computed from the next count value, so they are always consistent with count:
  - if_empty_n = (count ≠ 0)
  - if_full_n = (count ≠ DEPTH)
  - almost_full = (count ≥ AF_LEVEL)
  - almost_empty = (count ≤ AE_LEVEL)
- Error flags:
  - err_overflow sets on wr_req & !if_full_n; err_underflow sets on rd_req & !if_empty_n.
  - Both hold until reset; flush does not clear them.
  - A refused request in a flush cycle still sets its flag.
- Reset values:
  - if_empty_n=0, if_full_n=1, count=0, almost_full=0, almost_empty=1, err_overflow=0, err_underflow=0.

## Timing
- Write-to-read latency: 1 cycle. Data written at edge N is visible on if_dout, with if_empty_n=1, after edge N.
- Read-to-free latency: 1 cycle. if_full_n rises the cycle after a rd_acc from full.
- Flags and count change only on clock edges. There is no combinational path from if_read/if_write to any status output.
- if_dout changes combinationally only through the registered count and storage, so it is stable for the whole cycle.
- Reset asserted mid-operation: the next edge forces the reset values, and any queued tokens are lost.
- Wrap-around: count saturates structurally at 0 and DEPTH because acceptance is gated; count never wraps.

## Test plan
Configuration for all scenarios: DEPTH=4, DATA_WIDTH=8, AF_LEVEL=3, AE_LEVEL=1.

- Reset -> if_empty_n=0, if_full_n=1, count=0, almost_empty=1, almost_full=0, both error flags 0.
- Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles, no reads:
  - almost_full=1 after the third write; count=4 and if_full_n=0 after the fourth.
  - A fifth write with value 0x55 is dropped and sets err_overflow.
  - Then four reads return 0x11, 0x22, 0x33, 0x44, and count reaches 0.
- Hold count=2 (0xA0, 0xA1), then issue a simultaneous read+write of 0xA2 for 3 cycles:
  - count stays 2 throughout.
  - Reads return 0xA0, 0xA1, 0xA2 in order.
- From empty, assert read and write of 0x5A in the same cycle:
  - The read is refused and err_underflow=1.
  - count=1 next cycle, and if_dout=0x5A.
- At count=3, assert flush together with a write of 0x77:
  - Next cycle count=0, if_empty_n=0, if_full_n=1, almost_empty=1, almost_full=0.
  - The 0x77 is not stored, and err_overflow keeps its prior value.
- Toggle if_write_ce=0 while if_write=1 at count=4 -> no count change, and err_overflow is not set.
